// File: rtl/sc_player_move_fsm_if.sv
// Player movement bus: active-low button/event inputs and
// the shift strobes, position and lose flag driven back out.
interface sc_player_move_fsm_if #(
  parameter int COL_W = 3,
  parameter int ROW_W = 3
);
  logic             SC_PLAYER_MOVEFSM_LeftButton_InLow;
  logic             SC_PLAYER_MOVEFSM_RightButton_InLow;
  logic             SC_PLAYER_MOVEFSM_UpButton_InLow;
  logic             SC_PLAYER_MOVEFSM_DownButton_InLow;
  logic             SC_PLAYER_MOVEFSM_PlayerLose_InLow;
  logic             SC_PLAYER_MOVEFSM_FinishedLevel_InLow;
  logic [1:0]       SC_PLAYER_MOVEFSM_ShiftSelection_Out;
  logic [1:0]       SC_PLAYER_MOVEFSM_RowStep_Out;
  logic [COL_W-1:0] SC_PLAYER_MOVEFSM_Column_Out;
  logic [ROW_W-1:0] SC_PLAYER_MOVEFSM_Row_Out;
  logic             SC_PLAYER_MOVEFSM_Lose_Out;

  modport master (
    output SC_PLAYER_MOVEFSM_LeftButton_InLow,
    output SC_PLAYER_MOVEFSM_RightButton_InLow,
    output SC_PLAYER_MOVEFSM_UpButton_InLow,
    output SC_PLAYER_MOVEFSM_DownButton_InLow,
    output SC_PLAYER_MOVEFSM_PlayerLose_InLow,
    output SC_PLAYER_MOVEFSM_FinishedLevel_InLow,
    input  SC_PLAYER_MOVEFSM_ShiftSelection_Out,
    input  SC_PLAYER_MOVEFSM_RowStep_Out,
    input  SC_PLAYER_MOVEFSM_Column_Out,
    input  SC_PLAYER_MOVEFSM_Row_Out,
    input  SC_PLAYER_MOVEFSM_Lose_Out
  );

  modport slave (
    input  SC_PLAYER_MOVEFSM_LeftButton_InLow,
    input  SC_PLAYER_MOVEFSM_RightButton_InLow,
    input  SC_PLAYER_MOVEFSM_UpButton_InLow,
    input  SC_PLAYER_MOVEFSM_DownButton_InLow,
    input  SC_PLAYER_MOVEFSM_PlayerLose_InLow,
    input  SC_PLAYER_MOVEFSM_FinishedLevel_InLow,
    output SC_PLAYER_MOVEFSM_ShiftSelection_Out,
    output SC_PLAYER_MOVEFSM_RowStep_Out,
    output SC_PLAYER_MOVEFSM_Column_Out,
    output SC_PLAYER_MOVEFSM_Row_Out,
    output SC_PLAYER_MOVEFSM_Lose_Out
  );
endinterface

// File: rtl/sc_player_move_fsm.sv
// Frogger player movement FSM with edge clamp and lose/restart.
// Auto-repeat while held: define SC_PLAYER_MOVEFSM_AUTOREPEAT_EN.
module sc_player_move_fsm #(
  parameter int COLS          = 8,
  parameter int ROWS          = 8,
  parameter int START_COL     = 3,
  parameter int HOLD_CYCLES   = 12500000,
  parameter int REPEAT_CYCLES = 6250000,
  parameter int CNT_W         = 24
) (
  input  logic SC_PLAYER_MOVEFSM_CLOCK_50,
  input  logic SC_PLAYER_MOVEFSM_RESET_InLow,
  sc_player_move_fsm_if.slave io
);
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_RST = COL_W'(START_COL);
  localparam logic [CNT_W-1:0] HLD_LD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LD  = CNT_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, MOVE, HOLD, LOSE} state_t;
  typedef enum logic [1:0] {D_LEFT, D_RIGHT, D_UP, D_DOWN} dir_t;

  state_t           state, state_nxt;
  dir_t             dir, dir_nxt;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [CNT_W-1:0] timer;
  logic             rpt;

  logic left, right, up, down;
  logic restart, hit, held, legal;

  assign left    = ~io.SC_PLAYER_MOVEFSM_LeftButton_InLow;
  assign right   = ~io.SC_PLAYER_MOVEFSM_RightButton_InLow;
  assign up      = ~io.SC_PLAYER_MOVEFSM_UpButton_InLow;
  assign down    = ~io.SC_PLAYER_MOVEFSM_DownButton_InLow;
  assign hit     = ~io.SC_PLAYER_MOVEFSM_PlayerLose_InLow;
  assign restart = ~io.SC_PLAYER_MOVEFSM_FinishedLevel_InLow;

  always_comb begin
    held  = 1'b0;
    legal = 1'b0;
    unique case (dir)
      D_LEFT: begin
        held  = left;
        legal = (col != '0);
      end
      D_RIGHT: begin
        held  = right;
        legal = (col != COL_MAX);
      end
      D_UP: begin
        held  = up;
        legal = (row != ROW_MAX);
      end
      D_DOWN: begin
        held  = down;
        legal = (row != '0);
      end
      default: begin
        held  = 1'b0;
        legal = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_nxt = state;
    dir_nxt   = dir;
    if (restart) begin
      state_nxt = IDLE;
    end else if (hit && (state != LOSE)) begin
      state_nxt = LOSE;
    end else begin
      unique case (state)
        IDLE: begin
          if (left | right | up | down) begin
            state_nxt = MOVE;
            priority case (1'b1)
              left:    dir_nxt = D_LEFT;
              right:   dir_nxt = D_RIGHT;
              up:      dir_nxt = D_UP;
              default: dir_nxt = D_DOWN;
            endcase
          end
        end
        MOVE: state_nxt = HOLD;
        HOLD: begin
          if (!held) begin
            state_nxt = IDLE;
`ifdef SC_PLAYER_MOVEFSM_AUTOREPEAT_EN
          end else if (timer == '0) begin
            state_nxt = MOVE;
`endif
          end
        end
        LOSE:    state_nxt = LOSE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge SC_PLAYER_MOVEFSM_CLOCK_50 or
              negedge SC_PLAYER_MOVEFSM_RESET_InLow) begin
    if (!SC_PLAYER_MOVEFSM_RESET_InLow) begin
      state <= IDLE;
      dir   <= D_LEFT;
      col   <= COL_RST;
      row   <= '0;
      timer <= '0;
      rpt   <= 1'b0;
    end else begin
      state <= state_nxt;
      dir   <= dir_nxt;
      if (restart) begin
        col   <= COL_RST;
        row   <= '0;
        timer <= '0;
        rpt   <= 1'b0;
      end else begin
        // position follows the strobe that was just shown
        if ((state == MOVE) && legal) begin
          unique case (dir)
            D_LEFT:  col <= col - 1'b1;
            D_RIGHT: col <= col + 1'b1;
            D_UP:    row <= row + 1'b1;
            D_DOWN:  row <= row - 1'b1;
            default: col <= col;
          endcase
        end
        if (state == MOVE) begin
          timer <= rpt ? REP_LD : HLD_LD;
          rpt   <= 1'b1;
        end else if ((state == HOLD) && (timer != '0)) begin
          timer <= timer - 1'b1;
        end
        if ((state_nxt == IDLE) || (state_nxt == LOSE))
          rpt <= 1'b0;
      end
    end
  end

  always_comb begin
    io.SC_PLAYER_MOVEFSM_ShiftSelection_Out = 2'b00;
    io.SC_PLAYER_MOVEFSM_RowStep_Out        = 2'b00;
    if ((state == MOVE) && legal) begin
      unique case (dir)
        D_LEFT:  io.SC_PLAYER_MOVEFSM_ShiftSelection_Out = 2'b01;
        D_RIGHT: io.SC_PLAYER_MOVEFSM_ShiftSelection_Out = 2'b10;
        D_UP:    io.SC_PLAYER_MOVEFSM_RowStep_Out        = 2'b01;
        D_DOWN:  io.SC_PLAYER_MOVEFSM_RowStep_Out        = 2'b10;
        default: io.SC_PLAYER_MOVEFSM_RowStep_Out        = 2'b00;
      endcase
    end
  end

  assign io.SC_PLAYER_MOVEFSM_Column_Out = col;
  assign io.SC_PLAYER_MOVEFSM_Row_Out    = row;
  assign io.SC_PLAYER_MOVEFSM_Lose_Out   = (state == LOSE);
endmodule

// File: tb/tb_sc_player_move_fsm.sv
// Scoreboard bench for sc_player_move_fsm with short hold/repeat
// timers; expectations follow SC_PLAYER_MOVEFSM_AUTOREPEAT_EN.
module tb_sc_player_move_fsm;
  localparam logic [5:0] NONE = 6'b111111;
  localparam logic [5:0] BL   = 6'b011111;
  localparam logic [5:0] BR   = 6'b101111;
  localparam logic [5:0] BU   = 6'b110111;
  localparam logic [5:0] BD   = 6'b111011;
  localparam logic [5:0] PL   = 6'b111101;
  localparam logic [5:0] FN   = 6'b111110;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   ar_col;

  logic [16:0] stim[$];
  logic [10:0] sb[$];

  sc_player_move_fsm_if #(.COL_W(3), .ROW_W(3)) bus();

  sc_player_move_fsm #(
    .COLS(8), .ROWS(8), .START_COL(3),
    .HOLD_CYCLES(4), .REPEAT_CYCLES(2), .CNT_W(4)
  ) dut (
    .SC_PLAYER_MOVEFSM_CLOCK_50(clk),
    .SC_PLAYER_MOVEFSM_RESET_InLow(rst_n),
    .io(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set(input logic [5:0] v);
    bus.SC_PLAYER_MOVEFSM_LeftButton_InLow    = v[5];
    bus.SC_PLAYER_MOVEFSM_RightButton_InLow   = v[4];
    bus.SC_PLAYER_MOVEFSM_UpButton_InLow      = v[3];
    bus.SC_PLAYER_MOVEFSM_DownButton_InLow    = v[2];
    bus.SC_PLAYER_MOVEFSM_PlayerLose_InLow    = v[1];
    bus.SC_PLAYER_MOVEFSM_FinishedLevel_InLow = v[0];
  endtask

  function automatic logic [10:0] obs();
    return {bus.SC_PLAYER_MOVEFSM_ShiftSelection_Out,
            bus.SC_PLAYER_MOVEFSM_RowStep_Out,
            bus.SC_PLAYER_MOVEFSM_Column_Out,
            bus.SC_PLAYER_MOVEFSM_Row_Out,
            bus.SC_PLAYER_MOVEFSM_Lose_Out};
  endfunction

  function automatic logic [10:0] pk(input int sh, input int rs,
                                     input int c, input int r,
                                     input int l);
    return {2'(sh), 2'(rs), 3'(c), 3'(r), 1'(l)};
  endfunction

  task automatic add(input logic [5:0] v, input logic [10:0] e);
    stim.push_back({v, e});
  endtask

  task automatic add_tap(input logic [5:0] v, input int sh,
                         input int rs, input int c0, input int r0,
                         input int c1, input int r1);
    add(v, pk(sh, rs, c0, r0, 0));
    add(NONE, pk(0, 0, c1, r1, 0));
    add(NONE, pk(0, 0, c1, r1, 0));
  endtask

  task automatic test_reset();
    set(NONE);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (obs() !== pk(0, 0, 3, 0, 0)) begin
      errors++;
      $display("FAIL reset_state got %h exp %h", obs(), pk(0, 0, 3, 0, 0));
    end
    rst_n = 1'b1;
    @(negedge clk);
    set(BL);
    @(posedge clk);
    #1;
    checks++;
    if (bus.SC_PLAYER_MOVEFSM_ShiftSelection_Out !== 2'b01) begin
      errors++;
      $display("FAIL pre_reset_move got %b exp 01",
               bus.SC_PLAYER_MOVEFSM_ShiftSelection_Out);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs() !== pk(0, 0, 3, 0, 0)) begin
      errors++;
      $display("FAIL reset_mid_move got %h exp %h", obs(), pk(0, 0, 3, 0, 0));
    end
    set(NONE);
    @(negedge clk);
    checks++;
    if (obs() !== pk(0, 0, 3, 0, 0)) begin
      errors++;
      $display("FAIL reset_hold got %h exp %h", obs(), pk(0, 0, 3, 0, 0));
    end
    rst_n = 1'b1;
  endtask

  task automatic test_tap_left();
    logic [16:0] ent;
    logic [10:0] exp_v;
    int n = 0;
    add(BL, pk(1, 0, 3, 0, 0));
    add(BL, pk(0, 0, 2, 0, 0));
    add(BL, pk(0, 0, 2, 0, 0));
    add(NONE, pk(0, 0, 2, 0, 0));
    add(NONE, pk(0, 0, 2, 0, 0));
    add_tap(BR, 2, 0, 2, 0, 3, 0);
    while (stim.size() > 0) begin
      ent = stim.pop_front();
      set(ent[16:11]);
      sb.push_back(ent[10:0]);
      @(negedge clk);
      exp_v = sb.pop_front();
      checks++;
      if (obs() !== exp_v) begin
        errors++;
        $display("FAIL tap_left[%0d] got %h exp %h", n, obs(), exp_v);
      end
      n++;
    end
  endtask

  task automatic test_priority();
    logic [16:0] ent;
    logic [10:0] exp_v;
    int n = 0;
    add(BL & BU, pk(1, 0, 3, 0, 0));
    add(NONE, pk(0, 0, 2, 0, 0));
    add(NONE, pk(0, 0, 2, 0, 0));
    add(BU & BD, pk(0, 1, 2, 0, 0));
    add(NONE, pk(0, 0, 2, 1, 0));
    add(NONE, pk(0, 0, 2, 1, 0));
    add(BL, pk(1, 0, 2, 1, 0));
    add(BL & BR, pk(0, 0, 1, 1, 0));
    add(BR, pk(0, 0, 1, 1, 0));
    add(BR, pk(2, 0, 1, 1, 0));
    add(NONE, pk(0, 0, 2, 1, 0));
    add(NONE, pk(0, 0, 2, 1, 0));
    while (stim.size() > 0) begin
      ent = stim.pop_front();
      set(ent[16:11]);
      sb.push_back(ent[10:0]);
      @(negedge clk);
      exp_v = sb.pop_front();
      checks++;
      if (obs() !== exp_v) begin
        errors++;
        $display("FAIL priority[%0d] got %h exp %h", n, obs(), exp_v);
      end
      n++;
    end
  endtask

  task automatic test_clamp();
    logic [16:0] ent;
    logic [10:0] exp_v;
    int n = 0;
    add_tap(BL, 1, 0, 2, 1, 1, 1);
    add_tap(BL, 1, 0, 1, 1, 0, 1);
    add_tap(BL, 0, 0, 0, 1, 0, 1);
    for (int r = 1; r < 7; r++)
      add_tap(BU, 0, 1, 0, r, 0, r + 1);
    add_tap(BU, 0, 0, 0, 7, 0, 7);
    add(FN, pk(0, 0, 3, 0, 0));
    add(NONE, pk(0, 0, 3, 0, 0));
    add_tap(BD, 0, 0, 3, 0, 3, 0);
    for (int c = 3; c < 7; c++)
      add_tap(BR, 2, 0, c, 0, c + 1, 0);
    add_tap(BR, 0, 0, 7, 0, 7, 0);
    add(FN, pk(0, 0, 3, 0, 0));
    while (stim.size() > 0) begin
      ent = stim.pop_front();
      set(ent[16:11]);
      sb.push_back(ent[10:0]);
      @(negedge clk);
      exp_v = sb.pop_front();
      checks++;
      if (obs() !== exp_v) begin
        errors++;
        $display("FAIL clamp[%0d] got %h exp %h", n, obs(), exp_v);
      end
      n++;
    end
  endtask

  task automatic test_autorepeat();
    logic [16:0] ent;
    logic [10:0] exp_v;
    logic st;
    int n = 0;
    int c = 0;
    add_tap(BL, 1, 0, 3, 0, 2, 0);
    add_tap(BL, 1, 0, 2, 0, 1, 0);
    add_tap(BL, 1, 0, 1, 0, 0, 0);
    for (int k = 1; k <= 20; k++) begin
      st = (k == 1);
`ifdef SC_PLAYER_MOVEFSM_AUTOREPEAT_EN
      st = st || ((k >= 6) && ((k - 6) % 3 == 0));
`endif
      add(BR, pk(st ? 2 : 0, 0, c, 0, 0));
      if (st) c++;
    end
    add(NONE, pk(0, 0, c, 0, 0));
    add(NONE, pk(0, 0, c, 0, 0));
    ar_col = c;
    while (stim.size() > 0) begin
      ent = stim.pop_front();
      set(ent[16:11]);
      sb.push_back(ent[10:0]);
      @(negedge clk);
      exp_v = sb.pop_front();
      checks++;
      if (obs() !== exp_v) begin
        errors++;
        $display("FAIL autorepeat[%0d] got %h exp %h", n, obs(), exp_v);
      end
      n++;
    end
  endtask

  task automatic test_lose();
    logic [16:0] ent;
    logic [10:0] exp_v;
    int n = 0;
    add(PL & BR, pk(0, 0, ar_col, 0, 1));
    add(BR, pk(0, 0, ar_col, 0, 1));
    add(BL & BU, pk(0, 0, ar_col, 0, 1));
    add(NONE, pk(0, 0, ar_col, 0, 1));
    add(FN, pk(0, 0, 3, 0, 0));
    add(NONE, pk(0, 0, 3, 0, 0));
    add_tap(BR, 2, 0, 3, 0, 4, 0);
    add(FN & PL, pk(0, 0, 3, 0, 0));
    add(NONE, pk(0, 0, 3, 0, 0));
    while (stim.size() > 0) begin
      ent = stim.pop_front();
      set(ent[16:11]);
      sb.push_back(ent[10:0]);
      @(negedge clk);
      exp_v = sb.pop_front();
      checks++;
      if (obs() !== exp_v) begin
        errors++;
        $display("FAIL lose[%0d] got %h exp %h", n, obs(), exp_v);
      end
      n++;
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    ar_col = 0;
    test_reset();
    test_tap_left();
    test_priority();
    test_clamp();
    test_autorepeat();
    test_lose();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
